muller_mutex_core: RTL and testbench

- Clocked, synthesizable core for the async_lib handshake primitives.
- Contains two independent units:
  - A registered Muller C-element with N inputs.
  - A two-way mutual-exclusion element (mutex) with fair tie-break.
- Arbiter and pipeline blocks instantiate it wherever a C-element or a grant pair is needed in a synchronous flow.

---
 rtl/async_lib_pkg.sv | 31 +++
 rtl/c_element_reg.sv | 34 +++
 rtl/muller_mutex_core.sv | 98 +++++++++
 tb/tb_muller_mutex_core.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/async_lib_pkg.sv
// Shared types and helpers for the async_lib handshake primitives.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package async_lib_pkg;

    // Mutex arbitration states. Grants are decoded from these one-to-one.
    typedef enum logic [1:0] {
        MX_IDLE    = 2'd0,
        MX_GRANT_X = 2'd1,
        MX_GRANT_Y = 2'd2
    } mx_state_t;

    // Tie-break priority encoding: which side wins a simultaneous request.
    localparam logic MX_PRIO_X = 1'b0;
    localparam logic MX_PRIO_Y = 1'b1;

    // Muller C-element rule: follow the inputs when they agree, else hold.
    function automatic logic c_elem_next(input logic all_one,
                                         input logic all_zero,
                                         input logic cur);
        logic nxt;
        nxt = cur;
        if (all_one) begin
            nxt = 1'b1;
        end else if (all_zero) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage : async_lib_pkg

// File: rtl/c_element_reg.sv
// Registered N-input Muller C-element.
// Latency: 1 cycle from c_in to c_out; no combinational input-to-output path.
// Backpressure: none; output simply holds while inputs disagree.
module c_element_reg
    import async_lib_pkg::*;
#(
    parameter int   N         = 2,
    parameter logic C_RST_VAL = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_c_in,
    output logic         o_c_out
);

    logic r_c;
    logic w_all_one;
    logic w_all_zero;

    assign w_all_one  = &i_c_in;
    assign w_all_zero = ~|i_c_in;

    // Output register: set on unanimous ones, clear on unanimous zeros, else hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c <= C_RST_VAL;
        end else begin
            r_c <= c_elem_next(w_all_one, w_all_zero, r_c);
        end
    end

    assign o_c_out = r_c;

endmodule : c_element_reg

// File: rtl/muller_mutex_core.sv
// Registered Muller C-element plus a two-way fair mutex sharing one clock/reset.
// Latency: C-element 1 cycle; mutex grant 1 cycle after request, release 1 cycle after drop.
// Backpressure: none; an ungranted request waits, a withdrawn one is forgotten.
module muller_mutex_core
    import async_lib_pkg::*;
#(
    parameter int   N         = 2,
    parameter logic C_RST_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] c_in,
    output logic         c_out,
    input  logic         mx_x,
    input  logic         mx_y,
    output logic         mx_u,
    output logic         mx_v
);

    // ------------------------------------------------------------------
    // C-element: independent of the mutex apart from clk/rst.
    // ------------------------------------------------------------------
    c_element_reg #(
        .N         (N),
        .C_RST_VAL (C_RST_VAL)
    ) u_c_element (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_c_in  (c_in),
        .o_c_out (c_out)
    );

    // ------------------------------------------------------------------
    // Mutex. Every release returns to IDLE for at least one cycle, so the
    // opposite side is only granted on the following edge (break-before-make).
    // Priority flips to the other side whenever a grant is entered, which
    // alternates the winner of back-to-back simultaneous requests.
    // ------------------------------------------------------------------
    mx_state_t r_state;
    mx_state_t w_state_nxt;
    logic      r_prio;
    logic      w_prio_nxt;
    logic      r_u;
    logic      r_v;

    // State, priority and grant flops; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MX_IDLE;
            r_prio  <= MX_PRIO_X;
            r_u     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_u     <= (w_state_nxt == MX_GRANT_X);
            r_v     <= (w_state_nxt == MX_GRANT_Y);
        end
    end

    // Next-state and priority update for the mutex.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            MX_IDLE: begin
                if (mx_x && (!mx_y || (r_prio == MX_PRIO_X))) begin
                    w_state_nxt = MX_GRANT_X;
                    w_prio_nxt  = MX_PRIO_Y;
                end else if (mx_y) begin
                    w_state_nxt = MX_GRANT_Y;
                    w_prio_nxt  = MX_PRIO_X;
                end
            end
            MX_GRANT_X: begin
                if (!mx_x) begin
                    w_state_nxt = MX_IDLE;
                end
            end
            MX_GRANT_Y: begin
                if (!mx_y) begin
                    w_state_nxt = MX_IDLE;
                end
            end
            default: begin
                w_state_nxt = MX_IDLE;
            end
        endcase
    end

    // Grants come straight from flops, so they cannot glitch high together.
    assign mx_u = r_u;
    assign mx_v = r_v;

    // Grants are mutually exclusive on every edge.
    mx_excl_a: assert property (@(posedge clk) !(mx_u && mx_v));

endmodule : muller_mutex_core

// File: tb/tb_muller_mutex_core.sv
module tb_muller_mutex_core;

    localparam int N = 2;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic [N-1:0] c_in  = '0;
    logic         mx_x  = 1'b0;
    logic         mx_y  = 1'b0;
    logic         c_out;
    logic         mx_u;
    logic         mx_v;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muller_mutex_core #(
        .N         (N),
        .C_RST_VAL (1'b0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .c_in  (c_in),
        .c_out (c_out),
        .mx_x  (mx_x),
        .mx_y  (mx_y),
        .mx_u  (mx_u),
        .mx_v  (mx_v)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=nobody, 1=X, 2=Y; turn = side that wins a tie.
    logic m_c     = 1'b0;
    int   m_owner = 0;
    int   m_turn  = 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_c     = 1'b0;
            m_owner = 0;
            m_turn  = 1;
        end else begin
            if (c_in == {N{1'b1}})
                m_c = 1'b1;
            else if (c_in == '0)
                m_c = 1'b0;
            if (m_owner == 1) begin
                if (!mx_x) m_owner = 0;
            end else if (m_owner == 2) begin
                if (!mx_y) m_owner = 0;
            end else begin
                if (mx_x && mx_y)  m_owner = m_turn;
                else if (mx_x)     m_owner = 1;
                else if (mx_y)     m_owner = 2;
                if (m_owner != 0)  m_turn = 3 - m_owner;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("cmp_c_out", c_out, m_c);
            chk("cmp_u", mx_u, (m_owner == 1));
            chk("cmp_v", mx_v, (m_owner == 2));
        end
    end

    // Grants must never be high together, checked on every change.
    always @(mx_u or mx_v) begin
        chk("mutex_excl", (mx_u === 1'b1 && mx_v === 1'b1), 1'b0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] pat [5];
    logic         exp_c [5];

    initial begin
        pat[0] = 2'b00; exp_c[0] = 1'b0;
        pat[1] = 2'b01; exp_c[1] = 1'b0;
        pat[2] = 2'b11; exp_c[2] = 1'b1;
        pat[3] = 2'b10; exp_c[3] = 1'b1;
        pat[4] = 2'b00; exp_c[4] = 1'b0;

        // Reset with every input active: outputs clear before any clock edge.
        c_in = 2'b11; mx_x = 1'b1; mx_y = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_c_out", c_out, 1'b0);
        chk("rst_u", mx_u, 1'b0);
        chk("rst_v", mx_v, 1'b0);
        step();
        chk("rst_hold_c_out", c_out, 1'b0);
        chk("rst_hold_u", mx_u, 1'b0);
        chk("rst_hold_v", mx_v, 1'b0);

        // Release with quiet inputs.
        c_in = 2'b00; mx_x = 1'b0; mx_y = 1'b0;
        rst = 1'b1;

        // C-element sequence, one pattern per cycle.
        for (int i = 0; i < 5; i++) begin
            c_in = pat[i];
            step();
            chk("ce_seq", c_out, exp_c[i]);
            chk("ce_model", m_c, exp_c[i]);
        end

        // X alone, then Y queued behind it, then X releases.
        mx_x = 1'b1;
        step();
        chk("x_grant_u", mx_u, 1'b1);
        chk("x_grant_v", mx_v, 1'b0);
        mx_y = 1'b1;
        step();
        chk("y_blocked_u", mx_u, 1'b1);
        chk("y_blocked_v", mx_v, 1'b0);
        mx_x = 1'b0;
        step();
        chk("idle_gap_u", mx_u, 1'b0);
        chk("idle_gap_v", mx_v, 1'b0);
        step();
        chk("y_after_gap_v", mx_v, 1'b1);
        chk("y_after_gap_u", mx_u, 1'b0);

        // Simultaneous requests after reset: X wins, then priority alternates.
        mx_y = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        mx_x = 1'b1; mx_y = 1'b1;
        step();
        chk("tie1_u", mx_u, 1'b1);
        chk("tie1_v", mx_v, 1'b0);
        mx_x = 1'b0; mx_y = 1'b0;
        step();
        chk("tie_idle_u", mx_u, 1'b0);
        chk("tie_idle_v", mx_v, 1'b0);
        mx_x = 1'b1; mx_y = 1'b1;
        step();
        chk("tie2_u", mx_u, 1'b0);
        chk("tie2_v", mx_v, 1'b1);
        chk("tie2_model", (m_owner == 2), 1'b1);

        // Hold Y granted and drive the C-element high before a mid-grant reset.
        mx_x = 1'b0; c_in = 2'b11;
        step();
        chk("pre_rst_c_out", c_out, 1'b1);
        chk("pre_rst_v", mx_v, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_v", mx_v, 1'b0);
        chk("async_rst_u", mx_u, 1'b0);
        chk("async_rst_c_out", c_out, 1'b0);
        mx_y = 1'b1; c_in = 2'b00;
        #1 rst = 1'b1;
        step();
        chk("post_rst_v", mx_v, 1'b1);
        chk("post_rst_u", mx_u, 1'b0);

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 10000; i++) begin
            c_in = N'($urandom);
            mx_x = 1'($urandom);
            mx_y = 1'($urandom);
            step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_muller_mutex_core
